// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core constants and the fetch FSM state type
package riscv_pkg;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP = 32'h00000013;
  typedef enum logic [1:0] {REQ, WAIT, HOLD} fetch_state_t;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: fetches one instruction per pc over a req/gnt/rvalid bus and holds it for decode
module fetch_unit #(
  parameter int N = 32,
  parameter logic [riscv_pkg::ILEN-1:0] NOP = riscv_pkg::NOP
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N-1:0]              pc,
  output logic                      pc_advance,
  output logic                      mem_req,
  output logic [N-1:0]              mem_addr,
  input  logic                      mem_gnt,
  input  logic                      mem_rvalid,
  input  logic [riscv_pkg::ILEN-1:0] mem_rdata,
  input  logic                      mem_err,
  output logic                      instr_valid,
  output logic [riscv_pkg::ILEN-1:0] instr,
  output logic [N-1:0]              instr_pc,
  output logic                      fetch_err,
  input  logic                      instr_ready,
  input  logic                      flush,
  output logic [31:0]               fetch_count
);
  import riscv_pkg::*;
  fetch_state_t state, state_n;
  logic [N-1:0] req_pc;
  logic drop, drop_n, aligned, ld, ld_err;
  assign aligned = pc[1:0] == 2'b00;
  assign mem_addr = pc;
  assign mem_req = !reset && state == REQ && aligned;
  assign instr_valid = state == HOLD && !flush;
  assign pc_advance = !reset && instr_valid && instr_ready;
  // Next state; flush wins, and a response seen while dropping is consumed so drop clears
  always_comb begin
    state_n = state;
    drop_n = drop;
    ld = 1'b0;
    ld_err = 1'b0;
    if (state == REQ) begin
      if (mem_req && mem_gnt) begin
        state_n = WAIT;
        drop_n = flush;
      end else if (!aligned && !flush) begin
        state_n = HOLD;
        ld = 1'b1;
        ld_err = 1'b1;
      end
    end else if (state == WAIT) begin
      if (mem_rvalid) begin
        state_n = (drop || flush) ? REQ : HOLD;
        drop_n = 1'b0;
        ld = !(drop || flush);
        ld_err = mem_err;
      end else if (flush) drop_n = 1'b1;
    end else if (flush || instr_ready) state_n = REQ;
  end
  // FSM state and drop flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= REQ;
      drop <= 1'b0;
    end else begin
      state <= state_n;
      drop <= drop_n;
    end
  end
  // Request address capture, instruction holding register and accepted-instruction counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_pc <= '0;
      instr <= NOP;
      instr_pc <= '0;
      fetch_err <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (mem_req && mem_gnt) req_pc <= pc;
      if (ld) begin
        instr <= ld_err ? NOP : mem_rdata;
        instr_pc <= state == REQ ? pc : req_pc;
        fetch_err <= ld_err;
      end
      if (pc_advance) fetch_count <= fetch_count + 32'd1;
    end
  end
endmodule
